// File: rtl/mm_pkg.sv
// Shared encodings for the matvec operand/result memory arbiter.
package mm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_OWN_E = 2'b01,
        S_OWN_H = 2'b10
    } arb_state_e;

    localparam logic PORT_E = 1'b0;
    localparam logic PORT_H = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter (engine/host) in front of the single-port
// operand/result memory, with bounded bursts and tagged read-return steering.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nobody owns the memory; no grants, pick next owner
// S_OWN_E | engine owns the port; e_gnt follows e_req
// S_OWN_H | host owns the port; h_gnt follows h_req
module mem_port_arbiter
    import mm_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        owner
);

    localparam int              CNT_W     = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             last_owner_q, last_owner_d;
    logic             rd_pending_q, rd_pending_d;
    logic             rd_tag_q, rd_tag_d;

    logic             xfer;
    logic             xfer_we;
    logic             xfer_port;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            last_owner_q <= PORT_H;
            rd_pending_q <= 1'b0;
            rd_tag_q     <= PORT_E;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_owner_q <= last_owner_d;
            rd_pending_q <= rd_pending_d;
            rd_tag_q     <= rd_tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        e_gnt     = 1'b0;
        h_gnt     = 1'b0;
        xfer      = 1'b0;
        xfer_we   = 1'b0;
        xfer_port = PORT_E;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (e_req && h_req) begin
                    state_d = (last_owner_q == PORT_H) ? S_OWN_E : S_OWN_H;
                end else if (e_req) begin
                    state_d = S_OWN_E;
                end else if (h_req) begin
                    state_d = S_OWN_H;
                end
            end

            S_OWN_E: begin
                e_gnt     = e_req;
                xfer      = e_req;
                xfer_we   = e_we;
                xfer_port = PORT_E;
                mem_addr  = e_addr;
                mem_wdata = e_wdata;
                if (!e_req) begin
                    state_d = h_req ? S_OWN_H : S_IDLE;
                end else if ((beat_cnt_q == LAST_BEAT) && h_req) begin
                    state_d = S_OWN_H;
                end
            end

            S_OWN_H: begin
                h_gnt     = h_req;
                xfer      = h_req;
                xfer_we   = h_we;
                xfer_port = PORT_H;
                mem_addr  = h_addr;
                mem_wdata = h_wdata;
                if (!h_req) begin
                    state_d = e_req ? S_OWN_E : S_IDLE;
                end else if ((beat_cnt_q == LAST_BEAT) && e_req) begin
                    state_d = S_OWN_E;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Beat counter wraps freely while the other side is idle; only a state
    // change (including forced yield) clears it.
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        last_owner_d = last_owner_q;
        if (state_d != state_q) begin
            beat_cnt_d = '0;
            if (state_d == S_OWN_E) begin
                last_owner_d = PORT_E;
            end else if (state_d == S_OWN_H) begin
                last_owner_d = PORT_H;
            end
        end else if (xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    // Tag is captured at issue so a read stays with its requester across a handover.
    always_comb begin
        rd_pending_d = xfer & ~xfer_we;
        rd_tag_d     = rd_tag_q;
        if (rd_pending_d) begin
            rd_tag_d = xfer_port;
        end
    end

    assign mem_en   = xfer;
    assign mem_we   = xfer & xfer_we;

    assign e_rvalid = rd_pending_q & (rd_tag_q == PORT_E);
    assign h_rvalid = rd_pending_q & (rd_tag_q == PORT_H);
    assign e_rdata  = mem_rdata;
    assign h_rdata  = mem_rdata;

    assign owner    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural 64x16 memory.
module tb_mem_port_arbiter;
    import mm_pkg::*;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          e_req, e_we, h_req, h_we;
    logic [AW-1:0] e_addr, h_addr;
    logic [DW-1:0] e_wdata, h_wdata;
    logic          e_gnt, e_rvalid, h_gnt, h_rvalid;
    logic [DW-1:0] e_rdata, h_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    owner;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] sh  [64];
    logic          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
            mem_init = 1'b1;
        end
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t exp_e[$];
    exp_t exp_h[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (exp_e.size() > 0 && exp_e[0].due == cyc) begin
                chk("e_rvalid", {31'b0, e_rvalid}, 1);
                chk("e_rdata", {16'b0, e_rdata}, {16'b0, exp_e[0].d});
                exp_e.delete(0);
            end else if (e_rvalid) begin
                chk("e_rvalid_spurious", {31'b0, e_rvalid}, 0);
            end
            if (exp_h.size() > 0 && exp_h[0].due == cyc) begin
                chk("h_rvalid", {31'b0, h_rvalid}, 1);
                chk("h_rdata", {16'b0, h_rdata}, {16'b0, exp_h[0].d});
                exp_h.delete(0);
            end else if (h_rvalid) begin
                chk("h_rvalid_spurious", {31'b0, h_rvalid}, 0);
            end
        end
    end

    // One cycle: drive at posedge+1, check combinational outputs at negedge.
    task automatic step(input string nm,
                        input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                        input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                        input logic xeg, input logic xhg, input logic [1:0] xo);
        e_req = er; e_we = ew; e_addr = ea; e_wdata = ed;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        @(negedge clk);
        chk({nm, ".e_gnt"}, {31'b0, e_gnt}, {31'b0, xeg});
        chk({nm, ".h_gnt"}, {31'b0, h_gnt}, {31'b0, xhg});
        chk({nm, ".owner"}, {30'b0, owner}, {30'b0, xo});
        chk({nm, ".mem_en"}, {31'b0, mem_en}, {31'b0, (er & xeg) | (hr & xhg)});
        if (er & xeg) begin
            chk({nm, ".mem_addr"}, {26'b0, mem_addr}, {26'b0, ea});
            chk({nm, ".mem_we"}, {31'b0, mem_we}, {31'b0, ew});
            if (ew) begin
                chk({nm, ".mem_wdata"}, {16'b0, mem_wdata}, {16'b0, ed});
                sh[ea] = ed;
            end else begin
                exp_e.push_back('{d: sh[ea], due: cyc + 1});
            end
        end
        if (hr & xhg) begin
            chk({nm, ".mem_addr"}, {26'b0, mem_addr}, {26'b0, ha});
            chk({nm, ".mem_we"}, {31'b0, mem_we}, {31'b0, hw});
            if (hw) begin
                chk({nm, ".mem_wdata"}, {16'b0, mem_wdata}, {16'b0, hd});
                sh[ha] = hd;
            end else begin
                exp_h.push_back('{d: sh[ha], due: cyc + 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        exp_e.delete();
        exp_h.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".e_gnt"}, {31'b0, e_gnt}, 0);
        chk({nm, ".h_gnt"}, {31'b0, h_gnt}, 0);
        chk({nm, ".e_rvalid"}, {31'b0, e_rvalid}, 0);
        chk({nm, ".h_rvalid"}, {31'b0, h_rvalid}, 0);
        chk({nm, ".mem_en"}, {31'b0, mem_en}, 0);
        chk({nm, ".mem_we"}, {31'b0, mem_we}, 0);
        chk({nm, ".mem_addr"}, {26'b0, mem_addr}, 0);
        chk({nm, ".mem_wdata"}, {16'b0, mem_wdata}, 0);
        chk({nm, ".owner"}, {30'b0, owner}, {30'b0, S_IDLE});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) sh[i] = 16'hA000 + 16'(i);
        rst = 1'b0;
        idle_inputs();
        e_req = 1; h_req = 1; e_we = 1; e_addr = 6'h3F; e_wdata = 16'hFFFF;
        #2;
        chk_all_zero("rst0");
        do_reset();

        // 1: engine-only reads 0..3
        step("s1_idle", 1, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);
        for (int i = 0; i < 4; i++)
            step("s1_beat", 1, 0, 6'(i), 16'h0, 0, 0, 6'd0, 16'h0, 1, 0, S_OWN_E);
        step("s1_drop", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_OWN_E);
        step("s1_back", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);

        // 2: tie after reset, engine first, forced yield after 8 beats
        do_reset();
        step("s2_tie", 1, 0, 6'd8, 16'h0, 1, 0, 6'd16, 16'h0, 0, 0, S_IDLE);
        for (int i = 0; i < 8; i++)
            step("s2_e", 1, 0, 6'(8 + i), 16'h0, 1, 0, 6'd16, 16'h0, 1, 0, S_OWN_E);
        step("s2_h0", 1, 0, 6'd20, 16'h0, 1, 0, 6'd16, 16'h0, 0, 1, S_OWN_H);
        step("s2_h1", 1, 0, 6'd20, 16'h0, 1, 0, 6'd17, 16'h0, 0, 1, S_OWN_H);
        step("s2_hdrop", 1, 0, 6'd20, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_OWN_H);
        step("s2_eback", 1, 0, 6'd20, 16'h0, 0, 0, 6'd0, 16'h0, 1, 0, S_OWN_E);
        step("s2_edrop", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_OWN_E);
        step("s2_idle", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);

        // 3: 20 engine beats with host idle, write/read-back pairs
        do_reset();
        step("s3_idle", 1, 1, 6'd32, 16'h5000, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);
        for (int i = 0; i < 20; i++)
            step("s3_e", 1, (i % 2 == 0), 6'(32 + i / 2), 16'h5000 + 16'(i & ~1),
                 0, 0, 6'd0, 16'h0, 1, 0, S_OWN_E);
        step("s3_drop", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_OWN_E);

        // 4: host's last burst beat reads addr 5, engine then writes 0x1234 there
        do_reset();
        step("s4_idle", 0, 0, 6'd0, 16'h0, 1, 0, 6'd40, 16'h0, 0, 0, S_IDLE);
        for (int i = 0; i < 8; i++)
            step("s4_h", 1, 1, 6'd5, 16'h1234, 1, 0, (i == 7) ? 6'd5 : 6'(40 + i), 16'h0, 0, 1, S_OWN_H);
        step("s4_ewr", 1, 1, 6'd5, 16'h1234, 0, 0, 6'd0, 16'h0, 1, 0, S_OWN_E);
        step("s4_edrop", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_OWN_E);
        step("s4_idle2", 1, 0, 6'd5, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);
        step("s4_erd", 1, 0, 6'd5, 16'h0, 0, 0, 6'd0, 16'h0, 1, 0, S_OWN_E);
        step("s4_edrop2", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_OWN_E);
        chk("s4_mem5", {16'b0, mem[5]}, 32'h1234);

        // 5: e_req falls while h_req rises in S_OWN_E
        do_reset();
        step("s5_idle", 1, 0, 6'd1, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);
        step("s5_e", 1, 0, 6'd1, 16'h0, 0, 0, 6'd0, 16'h0, 1, 0, S_OWN_E);
        step("s5_swap", 0, 0, 6'd0, 16'h0, 1, 0, 6'd2, 16'h0, 0, 0, S_OWN_E);
        step("s5_h", 0, 0, 6'd0, 16'h0, 1, 0, 6'd2, 16'h0, 0, 1, S_OWN_H);
        step("s5_hdrop", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_OWN_H);
        step("s5_idle2", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);

        // 6: reset mid-burst with a read in flight
        do_reset();
        step("s6_idle", 1, 0, 6'd3, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);
        step("s6_e0", 1, 0, 6'd3, 16'h0, 0, 0, 6'd0, 16'h0, 1, 0, S_OWN_E);
        step("s6_e1", 1, 0, 6'd4, 16'h0, 0, 0, 6'd0, 16'h0, 1, 0, S_OWN_E);
        #1;
        rst = 1'b0;
        exp_e.delete();
        exp_h.delete();
        #1;
        chk_all_zero("s6_rst");
        chk("s6_rdata", {16'b0, e_rdata}, {16'b0, mem_rdata});
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            step("s6_after", 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, S_IDLE);

        chk("queues_empty", 32'(exp_e.size() + exp_h.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
